program_loader: RTL and testbench

//   Writer side of the CPU instruction-memory download path. Consumes a framed

---
 rtl/program_loader.sv | 190 +++++++++++++++++++
 tb/tb_program_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (length, 16-bit words, XOR checksum)
// and writes the words into the icache write port at consecutive indices. The CPU
// pipeline is held until a complete download has been checked and accepted.
module program_loader #(
  parameter int unsigned INDEX_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               download_program,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               write_enable,
  output logic [INDEX_W-1:0] write_index,
  output logic [15:0]        write_data,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_error
);

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned CTR_W     = INDEX_W + 1;
  localparam int unsigned MAX_WORDS = 32'(1) << INDEX_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_LEN_HI  = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_DATA_HI = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  logic [2:0]         state_q,        state_d;
  logic               byte_ready_q,   byte_ready_d;
  logic               write_enable_q, write_enable_d;
  logic [INDEX_W-1:0] write_index_q,  write_index_d;
  logic [15:0]        write_data_q,   write_data_d;
  logic               cpu_hold_q,     cpu_hold_d;
  logic               load_done_q,    load_done_d;
  logic               load_error_q,   load_error_d;
  logic [LEN_W-1:0]   count_q,        count_d;
  logic [CTR_W-1:0]   word_ctr_q,     word_ctr_d;
  logic [7:0]         csum_q,         csum_d;
  logic [7:0]         lo_q,           lo_d;

  logic               accept_c;
  logic [LEN_W-1:0]   len_c;
  logic               last_word_c;

  // Byte handshake, full length as seen while the high length byte arrives, and
  // detection of the final word of the frame.
  always_comb begin
    accept_c    = byte_valid & byte_ready_q;
    len_c       = {byte_data, count_q[7:0]};
    last_word_c = ((LEN_W'(word_ctr_q) + 16'd1) == count_q);
  end

  // Next-state and registered-output computation for the download FSM.
  always_comb begin
    state_d        = state_q;
    write_enable_d = 1'b0;
    write_index_d  = write_index_q;
    write_data_d   = write_data_q;
    cpu_hold_d     = cpu_hold_q;
    load_done_d    = load_done_q;
    load_error_d   = load_error_q;
    count_d        = count_q;
    word_ctr_d     = word_ctr_q;
    csum_d         = csum_q;
    lo_d           = lo_q;
    byte_ready_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (download_program) begin
          state_d      = S_LEN_LO;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          csum_d       = 8'h00;
          word_ctr_d   = '0;
          count_d      = '0;
        end
      end
      S_LEN_LO: begin
        if (accept_c) begin
          count_d = {8'h00, byte_data};
          csum_d  = csum_q ^ byte_data;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept_c) begin
          count_d = len_c;
          csum_d  = csum_q ^ byte_data;
          if (len_c == '0) begin
            state_d = S_CHECK;
          end else if (32'(len_c) > MAX_WORDS) begin
            // Program cannot fit: reject before touching the icache.
            state_d      = S_ERROR;
            load_error_d = 1'b1;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (accept_c) begin
          lo_d    = byte_data;
          csum_d  = csum_q ^ byte_data;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept_c) begin
          csum_d         = csum_q ^ byte_data;
          write_enable_d = 1'b1;
          write_index_d  = word_ctr_q[INDEX_W-1:0];
          write_data_d   = {byte_data, lo_q};
          word_ctr_d     = word_ctr_q + CTR_W'(1);
          state_d        = last_word_c ? S_CHECK : S_DATA_LO;
        end
      end
      S_CHECK: begin
        if (accept_c) begin
          if (byte_data == csum_q) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d      = S_ERROR;
            load_error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ready follows the state being entered so it is valid on the same cycle.
    byte_ready_d = (state_d == S_LEN_LO)  || (state_d == S_LEN_HI) ||
                   (state_d == S_DATA_LO) || (state_d == S_DATA_HI) ||
                   (state_d == S_CHECK);
  end

  // State and output registers; reset leaves the program marked invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      byte_ready_q   <= 1'b0;
      write_enable_q <= 1'b0;
      write_index_q  <= '0;
      write_data_q   <= 16'h0000;
      cpu_hold_q     <= 1'b1;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      count_q        <= '0;
      word_ctr_q     <= '0;
      csum_q         <= 8'h00;
      lo_q           <= 8'h00;
    end else begin
      state_q        <= state_d;
      byte_ready_q   <= byte_ready_d;
      write_enable_q <= write_enable_d;
      write_index_q  <= write_index_d;
      write_data_q   <= write_data_d;
      cpu_hold_q     <= cpu_hold_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
      count_q        <= count_d;
      word_ctr_q     <= word_ctr_d;
      csum_q         <= csum_d;
      lo_q           <= lo_d;
    end
  end

  // Output drive straight from the registers.
  always_comb begin
    byte_ready   = byte_ready_q;
    write_enable = write_enable_q;
    write_index  = write_index_q;
    write_data   = write_data_q;
    cpu_hold     = cpu_hold_q;
    load_done    = load_done_q;
    load_error   = load_error_q;
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives framed downloads into program_loader and compares the
// icache writes and final status with a frame-level reference model.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        download_program;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        write_enable;
  logic [7:0]  write_index;
  logic [15:0] write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int n_checks;
  int n_errors;

  logic [7:0]  frame_q[$];
  logic [23:0] exp_w[$];
  logic [23:0] got_w[$];
  logic        exp_done;
  logic        exp_err;

  program_loader #(.INDEX_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .download_program (download_program),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .write_enable     (write_enable),
    .write_index      (write_index),
    .write_data       (write_data),
    .cpu_hold         (cpu_hold),
    .load_done        (load_done),
    .load_error       (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every icache write strobe as {index, data}.
  always @(negedge clk) begin
    if (write_enable) got_w.push_back({write_index, write_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 0);
    chk({tag, "_we"},    32'(write_enable), 0);
    chk({tag, "_idx"},   32'(write_index), 0);
    chk({tag, "_data"},  32'(write_data), 0);
    chk({tag, "_hold"},  32'(cpu_hold), 1);
    chk({tag, "_done"},  32'(load_done), 0);
    chk({tag, "_err"},   32'(load_error), 0);
  endtask

  // Frame-level reference: decode length, list words, verify XOR checksum.
  task automatic run_model();
    int n;
    logic [7:0] x;
    exp_w.delete();
    n = int'({frame_q[1], frame_q[0]});
    if (n > 256) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      x = 8'h00;
      for (int i = 0; i < 2 + 2 * n; i++) x = x ^ frame_q[i];
      for (int k = 0; k < n; k++)
        exp_w.push_back({8'(k), frame_q[3 + 2 * k], frame_q[2 + 2 * k]});
      exp_done = (frame_q[2 + 2 * n] == x);
      exp_err  = !exp_done;
    end
  endtask

  task automatic build_frame(input int n, input bit idx_data, input bit bad);
    logic [15:0] len;
    logic [7:0]  x;
    logic [15:0] w;
    frame_q.delete();
    len = 16'(n);
    frame_q.push_back(len[7:0]);
    frame_q.push_back(len[15:8]);
    if (n <= 256) begin
      for (int k = 0; k < n; k++) begin
        w = idx_data ? 16'(k) : 16'($urandom);
        frame_q.push_back(w[7:0]);
        frame_q.push_back(w[15:8]);
      end
      x = 8'h00;
      foreach (frame_q[i]) x = x ^ frame_q[i];
      if (bad) x = x ^ 8'($urandom_range(255, 1));
      frame_q.push_back(x);
    end
  endtask

  // Start a download and push n_send bytes with optional gaps and a stray start pulse.
  task automatic send_frame(input int max_gap, input int pulse_at, input int n_send);
    int n_words;
    int gap;
    int t;
    bit len_ok;
    n_words = int'({frame_q[1], frame_q[0]});
    len_ok  = (n_words <= 256);
    got_w.delete();
    @(negedge clk);
    download_program = 1'b1;
    @(negedge clk);
    download_program = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = frame_q[i];
      if (i == pulse_at) download_program = 1'b1;
      t = 0;
      while (!byte_ready && t < 64) begin
        @(negedge clk);
        t++;
      end
      if (t >= 64) begin
        chk("ready_timeout", 0, 1);
        byte_valid       = 1'b0;
        download_program = 1'b0;
        return;
      end
      @(negedge clk);
      download_program = 1'b0;
      if (len_ok && i >= 3 && i < 2 + 2 * n_words && ((i - 2) % 2) == 1)
        chk("wr_latency", {23'd0, write_enable, write_index}, {23'd0, 1'b1, 8'((i - 3) / 2)});
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int max_gap, input int pulse_at);
    int n_send;
    run_model();
    n_send = (int'({frame_q[1], frame_q[0]}) > 256) ? 2 : frame_q.size();
    send_frame(max_gap, pulse_at, n_send);
    chk({tag, "_done"},  32'(load_done), 32'(exp_done));
    chk({tag, "_err"},   32'(load_error), 32'(exp_err));
    chk({tag, "_hold"},  32'(cpu_hold), 32'(!exp_done));
    chk({tag, "_ready"}, 32'(byte_ready), 0);
    @(negedge clk);
    chk({tag, "_nwr"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++)
      chk({tag, "_word"}, 32'(got_w[k]), 32'(exp_w[k]));
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    download_program = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    frame_q = '{8'h02, 8'h00, 8'h01, 8'h20, 8'h70, 8'h47, 8'h14};
    run_frame("t1", 0, -1);

    frame_q = '{8'h02, 8'h00, 8'h01, 8'h20, 8'h70, 8'h47, 8'h15};
    run_frame("t2", 0, -1);

    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame("t3a", 0, -1);

    frame_q = '{8'h01, 8'h01};
    run_frame("t3b", 0, -1);

    frame_q = '{8'h02, 8'h00, 8'h01, 8'h20, 8'h70, 8'h47, 8'h14};
    run_frame("t4", 5, 3);

    send_frame(0, -1, 5);
    reset = 1'b1;
    #1;
    chk_reset_vals("t5rst");
    @(negedge clk);
    reset = 1'b0;
    frame_q = '{8'h02, 8'h00, 8'h01, 8'h20, 8'h70, 8'h47, 8'h14};
    run_frame("t5", 0, -1);

    build_frame(256, 1'b1, 1'b0);
    run_frame("t6", 0, -1);

    for (int r = 0; r < 25; r++) begin
      n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(1200, 257)) : int'($urandom_range(10, 0));
      build_frame(n, 1'b0, ($urandom_range(3, 0) == 0));
      run_frame("rnd", 3, int'($urandom_range(2 * 10 + 2, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
